// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: reads a one- or two-byte instruction from a
// registered program memory and presents it to the decoder with valid/ready.
module instruction_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic       clk,
  input  logic       resetN,
  output logic [7:0] programAddress,
  input  logic [7:0] programMemoryOutput,
  output logic       instrValid,
  input  logic       instrReady,
  output logic [7:0] instrOpcode,
  output logic [7:0] instrOperand,
  output logic       instrHasOperand,
  output logic [7:0] instrPc,
  input  logic       jumpEnable,
  input  logic [7:0] jumpTarget
);

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    READ_OP   = 3'd1,
    FETCH_ARG = 3'd2,
    READ_ARG  = 3'd3,
    PRESENT   = 3'd4
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [7:0] pc;
  logic [7:0] nextPc;
  logic       opIsTwoByte;

  function automatic logic isTwoByte(input logic [7:0] op);
    return ((op >= 8'h01) && (op <= 8'h07)) || ((op >= 8'h14) && (op <= 8'h17));
  endfunction

  always_comb opIsTwoByte = isTwoByte(programMemoryOutput);

  // Address arithmetic wraps naturally in 8 bits.
  always_comb nextPc = pc + (instrHasOperand ? 8'd2 : 8'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= FETCH_OP;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (jumpEnable) begin
      nextState = FETCH_OP;
    end else begin
      case (state)
        FETCH_OP:  nextState = READ_OP;
        READ_OP:   nextState = opIsTwoByte ? FETCH_ARG : PRESENT;
        FETCH_ARG: nextState = READ_ARG;
        READ_ARG:  nextState = PRESENT;
        PRESENT:   nextState = instrReady ? FETCH_OP : PRESENT;
        default:   nextState = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    instrValid = 1'b0;
    if (state == PRESENT) begin
      instrValid = 1'b1;
    end
  end

  // A jump wins over every other update; a partial instruction is simply dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc              <= RESET_VECTOR;
      programAddress  <= RESET_VECTOR;
      instrOpcode     <= 8'h00;
      instrOperand    <= 8'h00;
      instrHasOperand <= 1'b0;
      instrPc         <= RESET_VECTOR;
    end else if (jumpEnable) begin
      pc             <= jumpTarget;
      programAddress <= jumpTarget;
    end else begin
      case (state)
        READ_OP: begin
          instrOpcode     <= programMemoryOutput;
          instrPc         <= pc;
          instrHasOperand <= opIsTwoByte;
          instrOperand    <= 8'h00;
          if (opIsTwoByte) begin
            programAddress <= pc + 8'd1;
          end
        end
        READ_ARG: begin
          instrOperand <= programMemoryOutput;
        end
        PRESENT: begin
          if (instrReady) begin
            pc             <= nextPc;
            programAddress <= nextPc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered 256-byte program memory.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] programAddress;
  logic [7:0] programMemoryOutput;
  logic       instrValid;
  logic       instrReady;
  logic [7:0] instrOpcode;
  logic [7:0] instrOperand;
  logic       instrHasOperand;
  logic [7:0] instrPc;
  logic       jumpEnable;
  logic [7:0] jumpTarget;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  logic [33:0] obs;
  logic [33:0] exp;
  logic [8:0]  vaObs;
  logic [8:0]  vaExp;

  always #5 clk = ~clk;

  always @(posedge clk) programMemoryOutput <= mem[programAddress];

  instruction_fetch #(.RESET_VECTOR(8'h00)) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .programAddress      (programAddress),
    .programMemoryOutput (programMemoryOutput),
    .instrValid          (instrValid),
    .instrReady          (instrReady),
    .instrOpcode         (instrOpcode),
    .instrOperand        (instrOperand),
    .instrHasOperand     (instrHasOperand),
    .instrPc             (instrPc),
    .jumpEnable          (jumpEnable),
    .jumpTarget          (jumpTarget)
  );

  // {valid, hasOperand, opcode, operand, instrPc, programAddress}
  function automatic logic [33:0] snap();
    return {instrValid, instrHasOperand, instrOpcode, instrOperand, instrPc, programAddress};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0; instrReady = 1'b1; jumpEnable = 1'b0; jumpTarget = 8'h00;
    step(3);
    checks++; obs = snap(); exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    if (obs !== exp) begin errors++; $display("FAIL reset_state got %h exp %h", obs, exp); end
  endtask

  task automatic test_two_byte();
    resetN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      checks++;
      if (instrValid !== 1'b0) begin errors++; $display("FAIL two_byte_latency cycle %0d got %b exp 0", i, instrValid); end
    end
    step(1);
    checks++; obs = snap(); exp = {1'b1, 1'b1, 8'h01, 8'hAA, 8'h00, 8'h01};
    if (obs !== exp) begin errors++; $display("FAIL two_byte_present got %h exp %h", obs, exp); end
    step(1);
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h02};
    if (vaObs !== vaExp) begin errors++; $display("FAIL two_byte_next_pc got %h exp %h", vaObs, vaExp); end
  endtask

  task automatic test_back_to_back();
    step(1);
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL b2b_read_op got %b exp 0", instrValid); end
    step(1);
    checks++; obs = snap(); exp = {1'b1, 1'b0, 8'h18, 8'h00, 8'h02, 8'h02};
    if (obs !== exp) begin errors++; $display("FAIL b2b_first got %h exp %h", obs, exp); end
    for (int i = 1; i <= 2; i++) begin
      step(1);
      checks++;
      if (instrValid !== 1'b0) begin errors++; $display("FAIL b2b_gap cycle %0d got %b exp 0", i, instrValid); end
    end
    step(1);
    checks++; obs = snap(); exp = {1'b1, 1'b0, 8'h0B, 8'h00, 8'h03, 8'h03};
    if (obs !== exp) begin errors++; $display("FAIL b2b_second got %h exp %h", obs, exp); end
  endtask

  task automatic test_stall();
    step(1);
    instrReady = 1'b0;
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h04};
    if (vaObs !== vaExp) begin errors++; $display("FAIL stall_fetch got %h exp %h", vaObs, vaExp); end
    step(3);
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL stall_read_arg got %b exp 0", instrValid); end
    step(1);
    exp = {1'b1, 1'b1, 8'h05, 8'h33, 8'h04, 8'h05};
    checks++; obs = snap();
    if (obs !== exp) begin errors++; $display("FAIL stall_present got %h exp %h", obs, exp); end
    for (int i = 1; i <= 5; i++) begin
      step(1);
      checks++; obs = snap();
      if (obs !== exp) begin errors++; $display("FAIL stall_hold cycle %0d got %h exp %h", i, obs, exp); end
    end
    instrReady = 1'b1;
    step(1);
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h06};
    if (vaObs !== vaExp) begin errors++; $display("FAIL stall_advance got %h exp %h", vaObs, vaExp); end
  endtask

  task automatic test_jump();
    step(1);
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL jump_read_op got %b exp 0", instrValid); end
    step(1);
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h07};
    if (vaObs !== vaExp) begin errors++; $display("FAIL jump_fetch_arg got %h exp %h", vaObs, vaExp); end
    jumpEnable = 1'b1; jumpTarget = 8'h10;
    step(1);
    jumpEnable = 1'b0;
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h10};
    if (vaObs !== vaExp) begin errors++; $display("FAIL jump_redirect got %h exp %h", vaObs, vaExp); end
    step(1);
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL jump_no_partial got %b exp 0", instrValid); end
    step(1);
    checks++; obs = snap(); exp = {1'b1, 1'b0, 8'h0C, 8'h00, 8'h10, 8'h10};
    if (obs !== exp) begin errors++; $display("FAIL jump_target_present got %h exp %h", obs, exp); end
  endtask

  task automatic test_jump_priority();
    instrReady = 1'b1; jumpEnable = 1'b1; jumpTarget = 8'hFF;
    step(1);
    jumpEnable = 1'b0;
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'hFF};
    if (vaObs !== vaExp) begin errors++; $display("FAIL jump_priority got %h exp %h", vaObs, vaExp); end
  endtask

  task automatic test_wrap();
    mem[8'h00] = 8'h0F;
    step(2);
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h00};
    if (vaObs !== vaExp) begin errors++; $display("FAIL wrap_arg_addr got %h exp %h", vaObs, vaExp); end
    step(2);
    checks++; obs = snap(); exp = {1'b1, 1'b1, 8'h02, 8'h0F, 8'hFF, 8'h00};
    if (obs !== exp) begin errors++; $display("FAIL wrap_present got %h exp %h", obs, exp); end
    step(1);
    checks++; vaObs = {instrValid, programAddress}; vaExp = {1'b0, 8'h01};
    if (vaObs !== vaExp) begin errors++; $display("FAIL wrap_next_pc got %h exp %h", vaObs, vaExp); end
    step(2);
    checks++; obs = snap(); exp = {1'b1, 1'b0, 8'hAA, 8'h00, 8'h01, 8'h01};
    if (obs !== exp) begin errors++; $display("FAIL wrap_following got %h exp %h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    jumpEnable = 1'b1; jumpTarget = 8'h04;
    step(1);
    jumpEnable = 1'b0;
    step(3);
    checks++; obs = snap(); exp = {1'b0, 1'b1, 8'h05, 8'h00, 8'h04, 8'h05};
    if (obs !== exp) begin errors++; $display("FAIL reset_mid_pre got %h exp %h", obs, exp); end
    #2 resetN = 1'b0;
    #1;
    checks++; obs = snap(); exp = {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    if (obs !== exp) begin errors++; $display("FAIL reset_async got %h exp %h", obs, exp); end
    step(1);
    resetN = 1'b1;
    step(1);
    checks++;
    if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_no_stale got %b exp 0", instrValid); end
    step(1);
    checks++; obs = snap(); exp = {1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00};
    if (obs !== exp) begin errors++; $display("FAIL reset_restart got %h exp %h", obs, exp); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'hAA;
    mem[8'h02] = 8'h18; mem[8'h03] = 8'h0B;
    mem[8'h04] = 8'h05; mem[8'h05] = 8'h33;
    mem[8'h06] = 8'h07; mem[8'h07] = 8'h99;
    mem[8'h10] = 8'h0C; mem[8'hFF] = 8'h02;
    test_reset();
    test_two_byte();
    test_back_to_back();
    test_stall();
    test_jump();
    test_jump_priority();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 8'h00, the first program address fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port programAddress, output, 8, registered byte address driven to program memory.
REQ-005 SHALL have port programMemoryOutput, input, 8, program memory data; it equals mem[programAddress as sampled at the previous rising edge].
REQ-006 SHALL have port instrValid, output, 1, meaning a complete instruction is presented.
REQ-007 SHALL have port instrReady, input, 1, meaning the decoder accepts the presented instruction.
REQ-008 SHALL have port instrOpcode, output, 8, the opcode byte.
REQ-009 SHALL have port instrOperand, output, 8, the operand byte, 8'h00 for one-byte instructions.
REQ-010 SHALL have port instrHasOperand, output, 1, high for two-byte instructions.
REQ-011 SHALL have port instrPc, output, 8, the address of the opcode byte.
REQ-012 SHALL have port jumpEnable, input, 1, a one-cycle request to redirect fetch.
REQ-013 SHALL have port jumpTarget, input, 8, the redirect address, valid when jumpEnable is high.

Function
REQ-014 SHALL classify opcodes 8'h01-8'h07 and 8'h14-8'h17 as two-byte; all other opcodes SHALL be one-byte.
REQ-015 SHALL implement the states FETCH_OP, READ_OP, FETCH_ARG, READ_ARG and PRESENT.
REQ-016 FETCH_OP: programAddress holds pc; the next state SHALL be READ_OP.
REQ-017 READ_OP: SHALL capture programMemoryOutput into instrOpcode. If the opcode is two-byte, programAddress SHALL become pc+1 and the next state FETCH_ARG. Otherwise instrOperand SHALL become 8'h00 and the next state PRESENT.
REQ-018 FETCH_ARG SHALL go to READ_ARG. READ_ARG SHALL capture programMemoryOutput into instrOperand and go to PRESENT.
REQ-019 PRESENT: instrValid SHALL be 1. All instr* outputs SHALL hold stable while instrReady is 0.
REQ-020 PRESENT with instrReady=1 and no jump: pc and programAddress SHALL become pc+1 (one-byte) or pc+2 (two-byte), and the next state SHALL be FETCH_OP.
REQ-021 instrValid SHALL be 0 in every state other than PRESENT.
REQ-022 Latency from entering FETCH_OP to instrValid SHALL be 2 cycles for one-byte and 4 cycles for two-byte instructions.
REQ-023 All address arithmetic SHALL be modulo 256. Operand fetch at pc=8'hFF SHALL read address 8'h00, and the next pc SHALL be 8'h01.
REQ-024 jumpEnable=1 in any state SHALL set pc and programAddress to jumpTarget and the state to FETCH_OP; instrValid SHALL be 0 the next cycle.
REQ-025 jumpEnable SHALL take priority over the normal advance when asserted with instrReady in PRESENT; the presented instruction counts as consumed.
REQ-026 jumpEnable during READ_OP, FETCH_ARG or READ_ARG SHALL discard the partial instruction without presenting it.

Reset
REQ-027 resetN=0 SHALL immediately force state FETCH_OP, pc=RESET_VECTOR, programAddress=RESET_VECTOR, instrValid=0, instrOpcode=8'h00, instrOperand=8'h00, instrHasOperand=0, instrPc=RESET_VECTOR.
REQ-028 Reset asserted mid-instruction SHALL abandon it; after release, fetch SHALL restart at RESET_VECTOR with no stale instruction presented.

Verification
REQ-029 Reset release with mem[0]=8'h01, mem[1]=8'hAA and instrReady=1 SHALL give, 4 cycles later, instrValid=1, opcode 8'h01, operand 8'hAA, hasOperand=1, instrPc=8'h00; the next instrPc SHALL be 8'h02.
REQ-030 mem[2]=8'h18 and mem[3]=8'h0B consumed back-to-back SHALL present 8'h18 at instrPc=8'h02, then 8'h0B at instrPc=8'h03, each with operand 8'h00, with 2 cycles of instrValid=0 between them.
REQ-031 instrReady held 0 for 5 cycles in PRESENT SHALL keep all instr* outputs constant, with no address change; asserting instrReady SHALL then advance.
REQ-032 jumpEnable=1 with jumpTarget=8'h10 during FETCH_ARG SHALL cause no instrValid for the partial instruction; the next presented instruction SHALL have instrPc=8'h10.
REQ-033 pc=8'hFF with mem[FF]=8'h02 and mem[00]=8'h0F SHALL present operand 8'h0F, and the next fetch SHALL be at 8'h01.
REQ-034 resetN pulsed low during READ_ARG SHALL force instrValid=0 with no clock edge; after release, instrPc SHALL equal RESET_VECTOR.
